// File: rtl/ram_fifo_pkg.sv
// Shared constants and counter types for the RAM-backed FIFO controller.
package ram_fifo_pkg;
    localparam int RAM_DATA_W    = 8;
    localparam int RAM_ADDR_W    = 6;
    localparam int RAM_DEPTH     = 1 << RAM_ADDR_W;
    localparam int OUT_BUF_DEPTH = 2;

    typedef logic [RAM_ADDR_W-1:0] ptr_t;
    typedef logic [RAM_ADDR_W:0]   ram_cnt_t;
    typedef logic [RAM_ADDR_W+1:0] fifo_cnt_t;
    typedef logic [1:0]            out_cnt_t;
endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry FIFO holding words returned by the RAM; the head register drives the read port.
module ram_fifo_outbuf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output out_cnt_t          o_cnt
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    out_cnt_t          r_cnt;

    // The controller never pushes into a full buffer or pops an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_push_data;
                    else               r_tail <= i_push_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// 64-entry valid/ready FIFO built around an external dual-port RAM with registered reads.
// Optional sticky overflow/underflow flags are enabled by defining RAM_FIFO_ERR_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W+1:0] count,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_in_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_in_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_data_out_b
`ifdef RAM_FIFO_ERR_EN
    ,
    output logic              err_ovf,
    output logic              err_udf
`endif
);

    localparam logic [ADDR_W:0]   L_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   L_RAM_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W+1:0] L_CNT_ONE = (ADDR_W+2)'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic [ADDR_W+1:0] r_count;
    logic              r_inflight;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;
    out_cnt_t          w_out_cnt;
    logic [DATA_W-1:0] w_head;

    assign wr_ready = (r_ram_cnt != L_DEPTH);
    assign rd_valid = (w_out_cnt != 2'd0);
    assign rd_data  = w_head;
    assign count    = r_count;

    assign w_push = wr_valid && wr_ready;
    assign w_pop  = rd_valid && rd_ready;

    // Output-buffer slots already claimed, counting the word still coming out of the RAM.
    assign w_occ   = {1'b0, w_out_cnt} + {2'b00, r_inflight};
    assign w_issue = (r_ram_cnt != '0) && ((w_occ - {2'b00, w_pop}) < 3'd2);

    assign ram_we_a      = w_push;
    assign ram_addr_a    = r_wr_ptr;
    assign ram_data_in_a = wr_data;
    assign ram_addr_b    = r_rd_ptr;
    assign ram_data_in_b = '0;
    assign ram_we_b      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_issue) r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            r_inflight <= w_issue;

            case ({w_push, w_issue})
                2'b10:   r_ram_cnt <= r_ram_cnt + L_RAM_ONE;
                2'b01:   r_ram_cnt <= r_ram_cnt - L_RAM_ONE;
                default: ;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: ;
            endcase
        end
    end

    ram_fifo_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (ram_data_out_b),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_cnt       (w_out_cnt)
    );

`ifdef RAM_FIFO_ERR_EN
    logic r_err_ovf;
    logic r_err_udf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) r_err_ovf <= 1'b1;
            if (rd_ready && !rd_valid) r_err_udf <= 1'b1;
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`endif

endmodule
